// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, the reserved "no producer" tag and the bus record
// consumed by reservation-station CDB inputs.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W = 4;
  localparam int unsigned CDB_TAG_W  = 4;

  localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, wrapping,
// and returns it both one-hot and encoded.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // One spare bit so ptr + k cannot overflow before the modulo-N fold.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus owner: grants one producer per cycle round-robin and broadcasts its
// {valid, tag, data} on a registered CDB one cycle after the handshake.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = CDB_DATA_W,
  parameter int unsigned TAG_W    = CDB_TAG_W,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        accepted,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
    $error("cdb_arbiter: NUM_REQ must be in 2..8");
  end
  if ((TAG_BASE + NUM_REQ - 1) >= (1 << TAG_W)) begin : gen_bad_tag_w
    $error("cdb_arbiter: TAG_W too narrow for TAG_BASE+NUM_REQ-1");
  end

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;

  logic               valid_d, valid_q;
  logic [TAG_W-1:0]   tag_d, tag_q;
  logic [DATA_W-1:0]  data_d, data_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .valid (grant_valid)
  );

  // Producers must not see a handshake while the bus is held in reset.
  assign accepted = rst ? '0 : grant;

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = 1'b0;
    tag_d   = TAG_W'(TAG_NONE);
    data_d  = '0;
    if (grant_valid) begin
      ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      valid_d = 1'b1;
      tag_d   = TAG_W'(TAG_BASE) + TAG_W'(grant_idx);
      data_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= TAG_W'(TAG_NONE);
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;

endmodule
